sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_CYCLES, default 960: clk cycles between refresh requests (~15 us at 64.8 MHz).
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 p0_req, p1_req  in  1 each  port request; held high until that port's ack.
REQ-006 p0_we, p1_we  in  1 each  1 = write, 0 = read; held stable while req is high.
REQ-007 p0_addr, p1_addr  in  23 each  word address; held stable while req is high.
REQ-008 p0_wdata, p1_wdata  in  32 each  write data; held stable while req is high.
REQ-009 p0_ack, p1_ack  out  1 each  one-cycle completion pulse.
REQ-010 p0_rdata, p1_rdata  out  32 each  read data; valid in the ack cycle and held until the next read ack on that port.
REQ-011 ctl_rd, ctl_wr, ctl_refresh  out  1 each  one-cycle command pulses to the SDRAM controller.
REQ-012 ctl_addr  out  23  controller address.
REQ-013 ctl_din  out  32  controller write data.
REQ-014 ctl_dout  in  32  controller read data.
REQ-015 ctl_data_ready  in  1  controller read-data strobe.
REQ-016 ctl_busy  in  1  controller busy; high during power-up init and during every operation.

Function
REQ-017 FSM states and transitions:
- IDLE -> ISSUE_WAIT when a command is issued.
- ISSUE_WAIT -> BUSY unconditionally, after one cycle.
- BUSY -> IDLE on the first cycle ctl_busy is sampled low.
REQ-018 Command issue in IDLE:
- Only when ctl_busy=0 and something is pending.
- Exactly one of ctl_rd/ctl_wr/ctl_refresh is registered high for one cycle.
- ctl_addr/ctl_din are registered in that same edge.
REQ-019 Refresh timer:
- Counts REFRESH_CYCLES-1 down to 0, then reloads.
- Reaching 0 sets the sticky flag refresh_pend.
- A further expiry while refresh_pend is set has no additional effect.
REQ-020 Priority: refresh_pend beats both ports; issuing ctl_refresh clears refresh_pend.
REQ-021 Port grant order between ports is set by the Configuration section.
REQ-022 Read capture: while in BUSY, ctl_dout is captured into the granted port's rdata register on the cycle ctl_data_ready=1.
REQ-023 Completion:
- The BUSY -> IDLE transition pulses the granted port's ack for one cycle; refresh produces no ack.
- The new IDLE state may issue again on the next cycle, giving a minimum one-cycle gap between commands.
REQ-024 A port's req sampled high in its own ack cycle is a new request.
REQ-025 Simultaneous events:
- Timer expiry in the same cycle as a port grant: the port command issues; the refresh issues next.
- Both ports requesting: exactly one is granted.
REQ-026 While ctl_busy=1 in IDLE (controller init), nothing issues; requests and refresh remain pending.
REQ-027 At most one ctl_* command pulse is outstanding at any time; ack never pulses for a port that was not granted.

Reset
REQ-028 When reset=1 at a rising edge, the following take their reset values:
- State = IDLE.
- All ctl_* outputs = 0; ctl_addr and ctl_din = 0.
- p0/p1_ack = 0; p0/p1_rdata = 0.
- refresh_pend = 0; timer reloaded to REFRESH_CYCLES-1.
- Round-robin pointer = port 0.
REQ-029 A reset mid-transaction abandons the transaction; no ack is issued for it.

Configuration
REQ-030 Macro SDRAM_ARB_ROUND_ROBIN_EN:
- Defined: round-robin grant; after a port-N grant, the other port has priority at the next conflict.
- Undefined: fixed priority, p0 always beats p1, and no pointer register exists.

Verification
REQ-031 Power-up: reset, hold ctl_busy=1 for 100 cycles with p0_req=1 -> no ctl_rd/ctl_wr pulse until ctl_busy=0, then exactly one pulse.
REQ-032 Read: p0 read of addr 0x000123, model returns 0xDEADBEEF -> ctl_rd pulse with ctl_addr=0x000123; p0_ack pulse; p0_rdata=0xDEADBEEF.
REQ-033 Write: p1 write of 0xCAFEF00D to 0x7FFFFF -> ctl_wr with ctl_din=0xCAFEF00D and ctl_addr=0x7FFFFF; p1_ack one cycle; p0_ack stays 0.
REQ-034 Contention: p0 and p1 both requesting continuously for 4 transactions ->
- With the macro: grants alternate p0, p1, p0, p1.
- Without the macro: p0 only.
REQ-035 Refresh: REFRESH_CYCLES=16, idle ports -> ctl_refresh every 16 cycles; with p0 saturating, a ctl_refresh precedes the next port command after each expiry.
REQ-036 Reset in BUSY during a p1 read -> no p1_ack; all outputs 0 on the next cycle.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port request arbiter with periodic refresh, feeding a single SDRAM controller.
// Optional macro SDRAM_ARB_ROUND_ROBIN_EN: round-robin port grant (undefined: p0 has fixed priority).
module sdram_arbiter #(
    parameter  int unsigned REFRESH_CYCLES = 960,
    localparam int unsigned AW             = 23,
    localparam int unsigned DW             = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,

    output logic          ctl_rd,
    output logic          ctl_wr,
    output logic          ctl_refresh,
    output logic [AW-1:0] ctl_addr,
    output logic [DW-1:0] ctl_din,
    input  logic [DW-1:0] ctl_dout,
    input  logic          ctl_data_ready,
    input  logic          ctl_busy
);

    localparam int unsigned   TW           = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE_WAIT = 2'd1,
        S_BUSY       = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic          r_refresh_pend;
    logic          r_gnt_ref;
    logic          r_gnt_p1;

    logic          w_pick_p1;
    logic          w_issue_ref;
    logic          w_issue_p0;
    logic          w_issue_p1;
    logic          w_issue;
    logic          w_done;
    logic          w_expire;
    logic          w_refresh_pend_nxt;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic          r_rr_p1;

    // r_rr_p1 set means p1 wins the next conflict
    assign w_pick_p1 = p1_req && (!p0_req || r_rr_p1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_p1 <= 1'b0;
        end else if (w_issue_p0) begin
            r_rr_p1 <= 1'b1;
        end else if (w_issue_p1) begin
            r_rr_p1 <= 1'b0;
        end
    end
`else
    assign w_pick_p1 = p1_req && !p0_req;
`endif

    // An expiry while refresh is already pending is absorbed by the sticky flag
    assign w_expire           = (r_timer == '0);
    assign w_refresh_pend_nxt = w_issue_ref ? 1'b0 : (r_refresh_pend | w_expire);
    assign w_issue            = w_issue_ref | w_issue_p0 | w_issue_p1;

    // Next-state and command-select logic
    always_comb begin
        w_state_nxt = r_state;
        w_issue_ref = 1'b0;
        w_issue_p0  = 1'b0;
        w_issue_p1  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!ctl_busy) begin
                    if (r_refresh_pend) begin
                        w_issue_ref = 1'b1;
                    end else if (w_pick_p1) begin
                        w_issue_p1 = 1'b1;
                    end else if (p0_req) begin
                        w_issue_p0 = 1'b1;
                    end
                end
                if (w_issue_ref || w_issue_p0 || w_issue_p1) begin
                    w_state_nxt = S_ISSUE_WAIT;
                end
            end
            S_ISSUE_WAIT: begin
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (!ctl_busy) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer        <= TIMER_RELOAD;
            r_refresh_pend <= 1'b0;
        end else begin
            r_timer        <= w_expire ? TIMER_RELOAD : (r_timer - TW'(1));
            r_refresh_pend <= w_refresh_pend_nxt;
        end
    end

    // Command pulses, controller payload and grant bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_rd      <= 1'b0;
            ctl_wr      <= 1'b0;
            ctl_refresh <= 1'b0;
            ctl_addr    <= '0;
            ctl_din     <= '0;
            r_gnt_ref   <= 1'b0;
            r_gnt_p1    <= 1'b0;
        end else begin
            ctl_rd      <= (w_issue_p0 && !p0_we) || (w_issue_p1 && !p1_we);
            ctl_wr      <= (w_issue_p0 &&  p0_we) || (w_issue_p1 &&  p1_we);
            ctl_refresh <= w_issue_ref;
            if (w_issue_p0) begin
                ctl_addr <= p0_addr;
                ctl_din  <= p0_wdata;
            end else if (w_issue_p1) begin
                ctl_addr <= p1_addr;
                ctl_din  <= p1_wdata;
            end
            if (w_issue) begin
                r_gnt_ref <= w_issue_ref;
                r_gnt_p1  <= w_issue_p1;
            end
        end
    end

    // Completion pulses and read-data capture for the granted port
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_ack <= w_done && !r_gnt_ref && !r_gnt_p1;
            p1_ack <= w_done && !r_gnt_ref &&  r_gnt_p1;
            if ((r_state == S_BUSY) && ctl_data_ready && !r_gnt_ref) begin
                if (r_gnt_p1) begin
                    p1_rdata <= ctl_dout;
                end else begin
                    p0_rdata <= ctl_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter with a small busy/data-ready controller model.
module tb_sdram_arbiter;

    localparam int unsigned RC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [22:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        ctl_rd, ctl_wr, ctl_refresh;
    logic [22:0] ctl_addr;
    logic [31:0] ctl_din, ctl_dout;
    logic        ctl_data_ready, ctl_busy;

    logic        init_busy;
    logic [31:0] m_rdata;
    int          m_cnt = 0;
    logic        m_is_rd = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rst_cyc = 0;
    int          n_rd = 0, n_wr = 0, n_ref = 0, n_p0ack = 0, n_p1ack = 0, n_multi = 0;
    logic [22:0] last_rd_addr = '0, last_wr_addr = '0;
    logic [31:0] last_wr_din = '0;
    int          ref_log[$];
    int          ack_log[$];

    sdram_arbiter #(.REFRESH_CYCLES(RC)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ctl_rd(ctl_rd), .ctl_wr(ctl_wr), .ctl_refresh(ctl_refresh),
        .ctl_addr(ctl_addr), .ctl_din(ctl_din), .ctl_dout(ctl_dout),
        .ctl_data_ready(ctl_data_ready), .ctl_busy(ctl_busy)
    );

    always #5 clk = ~clk;

    // Controller model: busy for 3 cycles after a command, read data one cycle before busy drops
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_cnt   <= 0;
            m_is_rd <= 1'b0;
        end else if (ctl_rd || ctl_wr || ctl_refresh) begin
            m_cnt   <= 3;
            m_is_rd <= ctl_rd;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign ctl_busy       = init_busy || (m_cnt != 0);
    assign ctl_data_ready = m_is_rd && (m_cnt == 1);
    assign ctl_dout       = ctl_data_ready ? m_rdata : 32'h0;

    always @(negedge clk) begin
        if (ctl_rd) begin n_rd++; last_rd_addr = ctl_addr; end
        if (ctl_wr) begin n_wr++; last_wr_addr = ctl_addr; last_wr_din = ctl_din; end
        if (ctl_refresh) begin n_ref++; ref_log.push_back(cyc); end
        if (p0_ack) begin n_p0ack++; ack_log.push_back(0); end
        if (p1_ack) begin n_p1ack++; ack_log.push_back(1); end
        if ((int'(ctl_rd) + int'(ctl_wr) + int'(ctl_refresh)) > 1 || (p0_ack && p1_ack)) n_multi++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick(2);
        reset   = 1'b0;
        rst_cyc = cyc;
    endtask

    task automatic wait_ack(input int port, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (port == 0 && p0_ack) begin got = 1'b1; p0_req = 1'b0; end
            if (port == 1 && p1_ack) begin got = 1'b1; p1_req = 1'b0; end
        end
    endtask

    task automatic test_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 23'h1;
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        checks++;
        if ({ctl_rd, ctl_wr, ctl_refresh, p0_ack, p1_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b required 00000", {ctl_rd, ctl_wr, ctl_refresh, p0_ack, p1_ack});
        end
        checks++;
        if (ctl_addr !== 23'h0) begin
            errors++; $display("FAIL reset_addr: got %h required 000000", ctl_addr);
        end
        checks++;
        if (ctl_din !== 32'h0) begin
            errors++; $display("FAIL reset_din: got %h required 00000000", ctl_din);
        end
        checks++;
        if ({p0_rdata, p1_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h required 0/0", p0_rdata, p1_rdata);
        end
        p0_req  = 1'b0;
        reset   = 1'b0;
        rst_cyc = cyc;
    endtask

    task automatic test_powerup();
        int base;
        bit got;
        init_busy = 1'b1;
        do_reset();
        m_rdata = 32'h11111111;
        p0_we = 1'b0; p0_addr = 23'h000055; p0_req = 1'b1;
        base = n_rd + n_wr;
        tick(100);
        checks++;
        if (n_rd + n_wr - base != 0) begin
            errors++; $display("FAIL powerup_hold: got %0d commands required 0", n_rd + n_wr - base);
        end
        init_busy = 1'b0;
        wait_ack(0, 60, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL powerup_ack: got no p0_ack required one");
        end
        p0_req = 1'b0;
        tick(20);
        checks++;
        if (n_rd + n_wr - base != 1) begin
            errors++; $display("FAIL powerup_count: got %0d commands required 1", n_rd + n_wr - base);
        end
    endtask

    task automatic test_read();
        int base;
        bit got;
        m_rdata = 32'hDEADBEEF;
        base = n_rd;
        p0_we = 1'b0; p0_addr = 23'h000123; p0_req = 1'b1;
        wait_ack(0, 60, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL read_ack: got no p0_ack required one");
        end
        checks++;
        if (p0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_data: got %h required deadbeef", p0_rdata);
        end
        checks++;
        if (last_rd_addr !== 23'h000123) begin
            errors++; $display("FAIL read_addr: got %h required 000123", last_rd_addr);
        end
        checks++;
        if (n_rd - base != 1) begin
            errors++; $display("FAIL read_count: got %0d ctl_rd required 1", n_rd - base);
        end
        checks++;
        if (p1_rdata !== 32'h0) begin
            errors++; $display("FAIL read_other_port: got p1_rdata %h required 00000000", p1_rdata);
        end
        tick(1);
        checks++;
        if (p0_ack !== 1'b0) begin
            errors++; $display("FAIL read_ack_width: got p0_ack %b required 0", p0_ack);
        end
    endtask

    task automatic test_write();
        int base_ack, base_wr;
        bit got;
        base_ack = n_p0ack;
        base_wr  = n_wr;
        p1_we = 1'b1; p1_addr = 23'h7FFFFF; p1_wdata = 32'hCAFEF00D; p1_req = 1'b1;
        wait_ack(1, 60, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL write_ack: got no p1_ack required one");
        end
        checks++;
        if (last_wr_addr !== 23'h7FFFFF || last_wr_din !== 32'hCAFEF00D) begin
            errors++; $display("FAIL write_payload: got %h/%h required 7fffff/cafef00d", last_wr_addr, last_wr_din);
        end
        checks++;
        if (n_wr - base_wr != 1) begin
            errors++; $display("FAIL write_count: got %0d ctl_wr required 1", n_wr - base_wr);
        end
        tick(1);
        checks++;
        if (p1_ack !== 1'b0) begin
            errors++; $display("FAIL write_ack_width: got p1_ack %b required 0", p1_ack);
        end
        checks++;
        if (n_p0ack - base_ack != 0) begin
            errors++; $display("FAIL write_p0_ack: got %0d p0_ack required 0", n_p0ack - base_ack);
        end
        checks++;
        if (p0_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_rdata_hold: got %h required deadbeef", p0_rdata);
        end
        p1_we = 1'b0;
    endtask

    task automatic test_contention();
        int b;
        bit done;
        logic [3:0] code;
        logic [3:0] exp_code;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        exp_code = 4'b0101;
`else
        exp_code = 4'b0000;
`endif
        do_reset();
        m_rdata = 32'h5A5A0001;
        b = ack_log.size();
        p0_we = 1'b0; p1_we = 1'b0; p0_addr = 23'h10; p1_addr = 23'h20;
        p0_req = 1'b1; p1_req = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ack_log.size() - b >= 4) done = 1'b1;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        checks++;
        if (!done) begin
            errors++; $display("FAIL contention_progress: got %0d acks required 4", ack_log.size() - b);
        end
        code = 4'b0;
        for (int i = 0; i < 4; i++) code = {code[2:0], (ack_log.size() > b + i) ? ack_log[b + i][0] : 1'bx};
        checks++;
        if (code !== exp_code) begin
            errors++; $display("FAIL contention_order: got %b required %b", code, exp_code);
        end
        tick(20);
    endtask

    task automatic test_refresh_idle();
        int b;
        do_reset();
        b = ref_log.size();
        tick(RC * 4 + 20);
        checks++;
        if (ref_log.size() - b < 4) begin
            errors++; $display("FAIL refresh_idle_count: got %0d required at least 4", ref_log.size() - b);
        end else begin
            checks++;
            if (ref_log[b] - rst_cyc != 17) begin
                errors++; $display("FAIL refresh_first: got offset %0d required 17", ref_log[b] - rst_cyc);
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (ref_log[b + i] - ref_log[b + i - 1] != RC) begin
                    errors++;
                    $display("FAIL refresh_interval: got %0d required %0d", ref_log[b + i] - ref_log[b + i - 1], RC);
                end
            end
        end
    endtask

    task automatic test_refresh_sat();
        int b, e, base_rd;
        bit got;
        m_rdata = 32'h0BADF00D;
        p0_we = 1'b0; p0_addr = 23'h44; p0_req = 1'b1;
        b = ref_log.size();
        base_rd = n_rd;
        tick(160);
        e = ref_log.size();
        checks++;
        if (e - b < 9 || e - b > 11) begin
            errors++; $display("FAIL refresh_sat_count: got %0d required 9..11", e - b);
        end
        for (int i = b + 1; i < e; i++) begin
            checks++;
            if (ref_log[i] - ref_log[i - 1] < 10 || ref_log[i] - ref_log[i - 1] > 22) begin
                errors++; $display("FAIL refresh_sat_gap: got %0d required 10..22", ref_log[i] - ref_log[i - 1]);
            end
        end
        checks++;
        if (n_rd - base_rd < 10) begin
            errors++; $display("FAIL refresh_sat_reads: got %0d required at least 10", n_rd - base_rd);
        end
        wait_ack(0, 40, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL refresh_sat_drain: got no p0_ack required one");
        end
        p0_req = 1'b0;
    endtask

    task automatic test_reset_busy();
        int base;
        bit seen;
        tick(10);
        m_rdata = 32'h12345678;
        p1_we = 1'b0; p1_addr = 23'h000ABC; p1_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ctl_rd) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rstbusy_issue: got no ctl_rd required one");
        end
        tick(2);
        reset  = 1'b1;
        p1_req = 1'b0;
        tick(1);
        checks++;
        if ({ctl_rd, ctl_wr, ctl_refresh, p0_ack, p1_ack} !== 5'b0 || ctl_addr !== 23'h0 || ctl_din !== 32'h0) begin
            errors++;
            $display("FAIL rstbusy_ctl: got %b %h %h required 00000 000000 00000000",
                     {ctl_rd, ctl_wr, ctl_refresh, p0_ack, p1_ack}, ctl_addr, ctl_din);
        end
        checks++;
        if ({p0_rdata, p1_rdata} !== 64'h0) begin
            errors++; $display("FAIL rstbusy_rdata: got %h/%h required 0/0", p0_rdata, p1_rdata);
        end
        reset = 1'b0;
        base = n_p1ack;
        tick(15);
        checks++;
        if (n_p1ack - base != 0) begin
            errors++; $display("FAIL rstbusy_ack: got %0d p1_ack required 0", n_p1ack - base);
        end
    endtask

    initial begin
        reset = 1'b0; init_busy = 1'b0; m_rdata = 32'h0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        test_reset();
        test_powerup();
        test_read();
        test_write();
        test_contention();
        test_refresh_idle();
        test_refresh_sat();
        test_reset_busy();
        checks++;
        if (n_multi != 0) begin
            errors++; $display("FAIL single_command: got %0d overlapping pulses required 0", n_multi);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
